// File: rtl/flexbex_ibex_pkg.sv
// flexbex_ibex_pkg: shared types for the flexbex ibex core
package flexbex_ibex_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        SKIP  = 2'd2
    } aligner_state_e;

endpackage

// File: rtl/flexbex_ibex_instr_aligner.sv
// flexbex_ibex_instr_aligner: turns word-aligned fetch words into one bit-0-aligned instruction per handshake
module flexbex_ibex_instr_aligner
    import flexbex_ibex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic [31:0] fetch_addr_i,
    input  logic        fetch_err_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_addr_o,
    output logic        instr_is_compressed_o,
    output logic        instr_err_o
);

    aligner_state_e state_q, state_d;
    logic [15:0]    hold_q, hold_d;
    logic [31:0]    hold_addr_q, hold_addr_d;
    logic           hold_err_q, hold_err_d;
    logic           hold_short;
    logic           unused_bits;

    // an errored upper halfword is retired alone so a bad word never pulls in another fetch
    assign hold_short            = (hold_q[1:0] != 2'b11) || hold_err_q;
    assign instr_is_compressed_o = instr_rdata_o[1:0] != 2'b11;
    assign unused_bits           = ^{fetch_addr_i[1:0], branch_addr_i[31:2], branch_addr_i[0]};

    // output selection, word consumption and next state; every consumed word refills hold with its upper half
    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        hold_addr_d   = hold_addr_q;
        hold_err_d    = hold_err_q;
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_rdata_o = fetch_rdata_i;
        instr_addr_o  = {fetch_addr_i[31:2], 2'b00};
        instr_err_o   = fetch_err_i;
        unique case (state_q)
            EMPTY: begin
                instr_valid_o = fetch_valid_i;
                fetch_ready_o = fetch_valid_i && instr_ready_i;
                if (fetch_rdata_i[1:0] != 2'b11) begin
                    instr_rdata_o = {16'h0, fetch_rdata_i[15:0]};
                    if (fetch_ready_o) state_d = HOLD;
                end
            end
            HOLD: begin
                instr_addr_o = hold_addr_q;
                if (hold_short) begin
                    instr_valid_o = 1'b1;
                    instr_rdata_o = {16'h0, hold_q};
                    instr_err_o   = hold_err_q;
                    if (instr_ready_i) state_d = EMPTY;
                end else begin
                    instr_valid_o = fetch_valid_i;
                    instr_rdata_o = {fetch_rdata_i[15:0], hold_q};
                    instr_err_o   = hold_err_q || fetch_err_i;
                    fetch_ready_o = fetch_valid_i && instr_ready_i;
                end
            end
            SKIP: begin
                fetch_ready_o = fetch_valid_i;
                if (fetch_valid_i) state_d = HOLD;
            end
            default: state_d = EMPTY;
        endcase
        if (clear_i) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
            state_d       = branch_addr_i[1] ? SKIP : EMPTY;
        end
        if (!rst_ni) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
        end
        if (fetch_ready_o) begin
            hold_d      = fetch_rdata_i[31:16];
            hold_addr_d = {fetch_addr_i[31:2], 2'b10};
            hold_err_d  = fetch_err_i;
        end
    end

    // state and hold registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= EMPTY;
            hold_q      <= '0;
            hold_addr_q <= '0;
            hold_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_addr_q <= hold_addr_d;
            hold_err_q  <= hold_err_d;
        end
    end

endmodule

// File: tb/tb_flexbex_ibex_instr_aligner.sv
// tb_flexbex_ibex_instr_aligner: directed and randomized checks against a halfword-stream reference model
module tb_flexbex_ibex_instr_aligner;

    logic        clk = 1'b0;
    logic        rst_n, clear, fetch_valid, fetch_ready, fetch_err;
    logic        instr_valid, instr_ready, instr_is_compressed, instr_err;
    logic [31:0] branch_addr, fetch_rdata, fetch_addr, instr_rdata, instr_addr;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [15:0] d;
        logic [31:0] a;
        logic        e;
    } hw_t;

    hw_t         q[$];
    bit          skip, have, stall;
    logic [31:0] src_addr, prev_d, prev_a;
    logic        prev_e;

    always #5 clk = ~clk;

    flexbex_ibex_instr_aligner dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .clear_i               (clear),
        .branch_addr_i         (branch_addr),
        .fetch_valid_i         (fetch_valid),
        .fetch_ready_o         (fetch_ready),
        .fetch_rdata_i         (fetch_rdata),
        .fetch_addr_i          (fetch_addr),
        .fetch_err_i           (fetch_err),
        .instr_valid_o         (instr_valid),
        .instr_ready_i         (instr_ready),
        .instr_rdata_o         (instr_rdata),
        .instr_addr_o          (instr_addr),
        .instr_is_compressed_o (instr_is_compressed),
        .instr_err_o           (instr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] d, input logic [31:0] a, input logic e);
        fetch_valid = 1'b1;
        fetch_rdata = d;
        fetch_addr  = a;
        fetch_err   = e;
    endtask

    task automatic expect_o(input string tag, input logic v, input logic fr, input logic [31:0] d, input logic [31:0] a);
        @(negedge clk);
        check({tag, "_valid"}, instr_valid, v);
        check({tag, "_fready"}, fetch_ready, fr);
        if (v) begin
            check({tag, "_data"}, instr_rdata, d);
            check({tag, "_addr"}, instr_addr, a);
            check({tag, "_cmp"}, instr_is_compressed, d[1:0] != 2'b11);
        end
    endtask

    // a halfword is a whole instruction if its opcode says compressed, or if it is an errored upper half
    function automatic bit short_hw(input hw_t h);
        return (h.d[1:0] != 2'b11) || (h.a[1] && h.e);
    endfunction

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 1) h[1:0] = 2'b11;
        return h;
    endfunction

    initial begin
        int          n_len;
        logic        exp_v, exp_r, need;
        logic [31:0] exp_d;
        rst_n = 1'b0; clear = 1'b0; branch_addr = '0; instr_ready = 1'b1;
        present(32'h0513_4501, 32'h100, 1'b0);
        step();
        expect_o("rst", 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        rst_n = 1'b1;
        present(32'h0001_4501, 32'h100, 1'b0);
        expect_o("t1a", 1'b1, 1'b1, 32'h0000_4501, 32'h100);
        step();
        fetch_valid = 1'b0;
        expect_o("t1b", 1'b1, 1'b0, 32'h0000_0001, 32'h102);
        step();
        present(32'h0513_4501, 32'h200, 1'b0);
        expect_o("t2a", 1'b1, 1'b1, 32'h0000_4501, 32'h200);
        step();
        present(32'h0000_0050, 32'h204, 1'b0);
        expect_o("t2b", 1'b1, 1'b1, 32'h0050_0513, 32'h202);
        step();
        fetch_valid = 1'b0;
        expect_o("t2c", 1'b1, 1'b0, 32'h0, 32'h206);
        step();
        present(32'h0001_4501, 32'h400, 1'b0);
        expect_o("t3a", 1'b1, 1'b1, 32'h0000_4501, 32'h400);
        step();
        present(32'h1111_1111, 32'h404, 1'b0);
        instr_ready = 1'b0;
        repeat (3) begin
            expect_o("t3stall", 1'b1, 1'b0, 32'h1, 32'h402);
            step();
        end
        instr_ready = 1'b1;
        expect_o("t3b", 1'b1, 1'b0, 32'h1, 32'h402);
        step();
        clear = 1'b1; branch_addr = 32'h302;
        expect_o("t4clr", 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        clear = 1'b0;
        present(32'h1234_ABCD, 32'h300, 1'b0);
        expect_o("t4skip", 1'b0, 1'b1, 32'h0, 32'h0);
        step();
        fetch_valid = 1'b0;
        expect_o("t4hold", 1'b1, 1'b0, 32'h0000_1234, 32'h302);
        step();
        present(32'h0513_4501, 32'h500, 1'b0);
        expect_o("t5a", 1'b1, 1'b1, 32'h0000_4501, 32'h500);
        check("t5a_err", instr_err, 1'b0);
        step();
        present(32'h0000_0050, 32'h504, 1'b1);
        expect_o("t5b", 1'b1, 1'b1, 32'h0050_0513, 32'h502);
        check("t5b_err", instr_err, 1'b1);
        step();
        fetch_valid = 1'b0;
        expect_o("t5c", 1'b1, 1'b0, 32'h0, 32'h506);
        check("t5c_err", instr_err, 1'b1);
        step();
        present(32'h0513_4501, 32'h600, 1'b0);
        expect_o("t6a", 1'b1, 1'b1, 32'h0000_4501, 32'h600);
        step();
        present(32'hDEAD_0050, 32'h604, 1'b0);
        clear = 1'b1; branch_addr = 32'h700;
        expect_o("t6clr", 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        clear = 1'b0;
        present(32'h00A0_0093, 32'h700, 1'b0);
        expect_o("t6new", 1'b1, 1'b1, 32'h00A0_0093, 32'h700);
        step();
        present(32'h0513_4501, 32'h800, 1'b0);
        expect_o("t7a", 1'b1, 1'b1, 32'h0000_4501, 32'h800);
        step();
        present(32'hDEAD_0050, 32'h804, 1'b0);
        rst_n = 1'b0;
        expect_o("t7rst", 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        rst_n = 1'b1;
        present(32'h0000_8082, 32'h900, 1'b0);
        expect_o("t7new", 1'b1, 1'b1, 32'h0000_8082, 32'h900);
        step();
        fetch_valid = 1'b0;
        expect_o("t7hold", 1'b1, 1'b0, 32'h0, 32'h902);
        step();
        rst_n = 1'b0; fetch_valid = 1'b0;
        have = 1'b0; skip = 1'b0; stall = 1'b0;
        src_addr = 32'hFFFF_FFE0;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (!rst_n) begin
                check("r_rst_valid", instr_valid, 1'b0);
                check("r_rst_fready", fetch_ready, 1'b0);
                q.delete(); skip = 1'b0; stall = 1'b0;
            end else if (clear) begin
                check("r_clr_valid", instr_valid, 1'b0);
                check("r_clr_fready", fetch_ready, 1'b0);
                q.delete(); skip = branch_addr[1]; stall = 1'b0;
            end else begin
                exp_v = skip ? 1'b0 : (q.size() != 0 && short_hw(q[0])) ? 1'b1 : fetch_valid;
                need  = q.size() == 0 || !short_hw(q[0]);
                exp_r = skip ? fetch_valid : exp_v && instr_ready && need;
                check("r_valid", instr_valid, exp_v);
                check("r_fready", fetch_ready, exp_r);
                if (stall && instr_valid) begin
                    check("r_stall_data", instr_rdata, prev_d);
                    check("r_stall_addr", instr_addr, prev_a);
                    check("r_stall_err", instr_err, prev_e);
                end
                if (fetch_valid && fetch_ready) begin
                    if (!skip) q.push_back(hw_t'{fetch_rdata[15:0], {fetch_addr[31:2], 2'b00}, fetch_err});
                    q.push_back(hw_t'{fetch_rdata[31:16], {fetch_addr[31:2], 2'b10}, fetch_err});
                    skip = 1'b0; have = 1'b0;
                end
                if (instr_valid && instr_ready) begin
                    n_len = (q.size() != 0 && short_hw(q[0])) ? 1 : 2;
                    check("r_avail", q.size() >= n_len, 1'b1);
                    if (q.size() >= n_len) begin
                        exp_d = (n_len == 1) ? {16'h0, q[0].d} : {q[1].d, q[0].d};
                        check("r_data", instr_rdata, exp_d);
                        check("r_addr", instr_addr, q[0].a);
                        check("r_err", instr_err, (n_len == 1) ? q[0].e : (q[0].e | q[1].e));
                        check("r_cmp", instr_is_compressed, exp_d[1:0] != 2'b11);
                        repeat (n_len) void'(q.pop_front());
                    end
                end
                stall  = instr_valid && !instr_ready;
                prev_d = instr_rdata; prev_a = instr_addr; prev_e = instr_err;
            end
            step();
            rst_n = $urandom_range(0, 299) != 0;
            clear = rst_n && $urandom_range(0, 29) == 0;
            if (!rst_n) begin
                have = 1'b0;
                src_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (clear) branch_addr = $urandom & 32'hFFFF_FFFE;
            if (!have) begin
                fetch_valid = $urandom_range(0, 3) != 0;
                if (fetch_valid) begin
                    present({rand_hw(), rand_hw()}, src_addr, $urandom_range(0, 15) == 0);
                    have = 1'b1;
                    src_addr += 4;
                end
            end
            if (clear) begin
                have = 1'b0;
                src_addr = {branch_addr[31:2], 2'b00};
            end
            instr_ready = $urandom_range(0, 3) != 0;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
